// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side driver for the register file. Two producers (ALU and memory)
//   hand results over through valid/ready. Accepted results are queued in an
//   in-order FIFO and retired one per cycle onto writeIndex/writeData/regWrite.
//   Pending data is forwarded to the two decode read ports.
//
// Ports
//   CLK, RST                         clock, async active-high reset
//   alu_valid/index/data, alu_ready  ALU producer handshake
//   mem_valid/index/data, mem_ready  memory producer handshake
//   wb_stall                         hold the FIFO head, issue nothing
//   writeIndex/writeData/regWrite    registered register-file write port
//   indexA/indexB                    decode read indices
//   fwdA_*/fwdB_*                    newest pending data for indexA/indexB
//   pending                          registered FIFO occupancy

// One forwarding read port. Entries arrive age-ordered (0 = oldest), so a
// later match simply overrides an earlier one and the youngest wins.
module regfile_writeback_fwd #(
   parameter int WIDTH = 32,
   parameter int COUNT = 5,
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0][COUNT-1:0] q_idx,
   input  logic [DEPTH-1:0][WIDTH-1:0] q_dat,
   input  logic [DEPTH-1:0]            q_vld,
   input  logic                        out_vld,
   input  logic [COUNT-1:0]            out_idx,
   input  logic [WIDTH-1:0]            out_dat,
   input  logic [COUNT-1:0]            rd_idx,
   output logic                        hit,
   output logic [WIDTH-1:0]            data
);
   always_comb begin
      hit  = 1'b0;
      data = '0;
      // output register is the oldest pending value
      if (out_vld && out_idx == rd_idx) begin
         hit  = 1'b1;
         data = out_dat;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (q_vld[i] && q_idx[i] == rd_idx) begin
            hit  = 1'b1;
            data = q_dat[i];
         end
      end
      // r0 is hardwired; never forward it
      if (rd_idx == '0) begin
         hit  = 1'b0;
         data = '0;
      end
   end
endmodule

module regfile_writeback #(
   parameter int WIDTH = 32,
   parameter int COUNT = 5,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             alu_valid,
   input  logic [COUNT-1:0] alu_index,
   input  logic [WIDTH-1:0] alu_data,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [COUNT-1:0] mem_index,
   input  logic [WIDTH-1:0] mem_data,
   output logic             mem_ready,
   input  logic             wb_stall,
   output logic [COUNT-1:0] writeIndex,
   output logic [WIDTH-1:0] writeData,
   output logic             regWrite,
   input  logic [COUNT-1:0] indexA,
   input  logic [COUNT-1:0] indexB,
   output logic             fwdA_valid,
   output logic             fwdB_valid,
   output logic [WIDTH-1:0] fwdA_data,
   output logic [WIDTH-1:0] fwdB_data,
   output logic [COUNT-1:0] pending
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][COUNT-1:0] idx_q;
   logic [DEPTH-1:0][WIDTH-1:0] dat_q;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [COUNT-1:0]            wr_idx_q;
   logic [WIDTH-1:0]            wr_dat_q;
   logic                        wr_en_q;

   logic [CW-1:0] free, enq_cnt;
   logic          alu_enq, mem_enq, deq;
   logic [PW-1:0] mem_slot;

   // Credit comes from the registered count only; a pop this cycle does
   // not open a slot until next cycle.
   assign free      = CW'(DEPTH) - cnt_q;
   assign alu_ready = (free != '0);
   assign mem_ready = (free >= CW'(2)) || (free == CW'(1) && !alu_valid);

   // r0 handshakes complete but are dropped here
   assign alu_enq  = alu_valid && alu_ready && (alu_index != '0);
   assign mem_enq  = mem_valid && mem_ready && (mem_index != '0);
   assign enq_cnt  = CW'(alu_enq) + CW'(mem_enq);
   assign deq      = (cnt_q != '0) && !wb_stall;

   // ALU is older when both land in the same cycle
   assign mem_slot = wr_ptr_q + PW'(alu_enq);
   assign wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
   assign rd_ptr_d = rd_ptr_q + PW'(deq);
   assign cnt_d    = cnt_q + enq_cnt - CW'(deq);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q    <= '0;
         dat_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         wr_idx_q <= '0;
         wr_dat_q <= '0;
         wr_en_q  <= 1'b0;
      end else begin
         if (alu_enq) begin
            idx_q[wr_ptr_q] <= alu_index;
            dat_q[wr_ptr_q] <= alu_data;
         end
         if (mem_enq) begin
            idx_q[mem_slot] <= mem_index;
            dat_q[mem_slot] <= mem_data;
         end
         if (deq) begin
            wr_idx_q <= idx_q[rd_ptr_q];
            wr_dat_q <= dat_q[rd_ptr_q];
         end
         wr_en_q  <= deq;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign writeIndex = wr_idx_q;
   assign writeData  = wr_dat_q;
   assign regWrite   = wr_en_q;
   assign pending    = COUNT'(cnt_q);

   // FIFO contents re-ordered oldest-first for the forwarding ports
   logic [DEPTH-1:0][COUNT-1:0] age_idx;
   logic [DEPTH-1:0][WIDTH-1:0] age_dat;
   logic [DEPTH-1:0]            age_vld;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_idx[i] = idx_q[rd_ptr_q + PW'(i)];
         age_dat[i] = dat_q[rd_ptr_q + PW'(i)];
         age_vld[i] = (CW'(i) < cnt_q);
      end
   end

   logic [1:0][COUNT-1:0] rd_idx;
   logic [1:0]            fwd_hit;
   logic [1:0][WIDTH-1:0] fwd_dat;

   assign rd_idx = {indexB, indexA};

   for (genvar p = 0; p < 2; p++) begin : g_fwd
      regfile_writeback_fwd #(
         .WIDTH(WIDTH), .COUNT(COUNT), .DEPTH(DEPTH)
      ) u_fwd (
         .q_idx  (age_idx),
         .q_dat  (age_dat),
         .q_vld  (age_vld),
         .out_vld(wr_en_q),
         .out_idx(wr_idx_q),
         .out_dat(wr_dat_q),
         .rd_idx (rd_idx[p]),
         .hit    (fwd_hit[p]),
         .data   (fwd_dat[p])
      );
   end

   assign fwdA_valid = fwd_hit[0];
   assign fwdA_data  = fwd_dat[0];
   assign fwdB_valid = fwd_hit[1];
   assign fwdB_data  = fwd_dat[1];
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
   logic        CLK, RST;
   logic        alu_valid, mem_valid, wb_stall;
   logic [4:0]  alu_index, mem_index, indexA, indexB;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready, regWrite;
   logic [4:0]  writeIndex, pending;
   logic [31:0] writeData, fwdA_data, fwdB_data;
   logic        fwdA_valid, fwdB_valid;

   int n_cmp = 0;
   int n_err = 0;

   regfile_writeback #(.WIDTH(32), .COUNT(5), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data), .mem_ready(mem_ready),
      .wb_stall(wb_stall),
      .writeIndex(writeIndex), .writeData(writeData), .regWrite(regWrite),
      .indexA(indexA), .indexB(indexB),
      .fwdA_valid(fwdA_valid), .fwdB_valid(fwdB_valid),
      .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
      .pending(pending)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // advance one posedge, settle 1ns after it
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0;
      alu_index = 0; mem_index = 0;
      alu_data  = 0; mem_data  = 0;
   endtask

   initial begin
      int exp_next;
      RST = 1; wb_stall = 0; indexA = 0; indexB = 0;
      idle();
      cyc(); cyc();
      // reset state
      chk("rst_regWrite", 32'(regWrite), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_writeIndex", 32'(writeIndex), 0);
      chk("rst_writeData", writeData, 0);
      RST = 0; #1;
      chk("rst_alu_ready", 32'(alu_ready), 1);
      chk("rst_mem_ready", 32'(mem_ready), 1);

      // single ALU result
      alu_valid = 1; alu_index = 5; alu_data = 32'hDEADBEEF; indexA = 5; #1;
      chk("single_alu_ready", 32'(alu_ready), 1);
      cyc(); idle(); #1;
      chk("single_pending", 32'(pending), 1);
      chk("single_no_write_yet", 32'(regWrite), 0);
      chk("single_fwd_valid", 32'(fwdA_valid), 1);
      chk("single_fwd_data", fwdA_data, 32'hDEADBEEF);
      cyc();
      chk("single_regWrite", 32'(regWrite), 1);
      chk("single_writeIndex", 32'(writeIndex), 5);
      chk("single_writeData", writeData, 32'hDEADBEEF);
      chk("single_pending_drain", 32'(pending), 0);
      chk("single_fwd_outreg", fwdA_data, 32'hDEADBEEF);
      cyc();
      chk("single_pulse_end", 32'(regWrite), 0);
      chk("single_hold_index", 32'(writeIndex), 5);

      // dual accept, same destination
      alu_valid = 1; alu_index = 3; alu_data = 32'h11;
      mem_valid = 1; mem_index = 3; mem_data = 32'h22; indexA = 3; #1;
      chk("dual_alu_ready", 32'(alu_ready), 1);
      chk("dual_mem_ready", 32'(mem_ready), 1);
      cyc(); idle(); #1;
      chk("dual_pending", 32'(pending), 2);
      chk("dual_fwd_valid", 32'(fwdA_valid), 1);
      chk("dual_fwd_newest", fwdA_data, 32'h22);
      cyc();
      chk("dual_w1_en", 32'(regWrite), 1);
      chk("dual_w1_data", writeData, 32'h11);
      chk("dual_fwd_still_newest", fwdA_data, 32'h22);
      cyc();
      chk("dual_w2_en", 32'(regWrite), 1);
      chk("dual_w2_index", 32'(writeIndex), 3);
      chk("dual_w2_data", writeData, 32'h22);
      cyc();
      chk("dual_done", 32'(regWrite), 0);

      // full / priority under stall
      wb_stall = 1;
      alu_valid = 1; alu_index = 4; alu_data = 32'h44;
      mem_valid = 1; mem_index = 5; mem_data = 32'h55;
      cyc(); idle();
      alu_valid = 1; alu_index = 6; alu_data = 32'h66;
      cyc(); idle(); #1;
      chk("full_pending3", 32'(pending), 3);
      alu_valid = 1; alu_index = 7; alu_data = 32'h77;
      mem_valid = 1; mem_index = 8; mem_data = 32'h88; #1;
      chk("full_alu_prio", 32'(alu_ready), 1);
      chk("full_mem_blocked", 32'(mem_ready), 0);
      cyc(); #1;
      chk("full_pending4", 32'(pending), 4);
      chk("full_alu_ready_low", 32'(alu_ready), 0);
      chk("full_mem_ready_low", 32'(mem_ready), 0);
      indexA = 7; indexB = 8; #1;
      chk("full_fwdA_valid", 32'(fwdA_valid), 1);
      chk("full_fwdA_data", fwdA_data, 32'h77);
      chk("full_fwdB_miss", 32'(fwdB_valid), 0);
      chk("full_fwdB_zero", fwdB_data, 0);
      cyc();
      chk("full_hold_pending", 32'(pending), 4);
      chk("full_hold_nowrite", 32'(regWrite), 0);
      idle(); wb_stall = 0;
      cyc();
      chk("full_w1", {writeIndex, writeData[26:0]}, {5'd4, 27'h44});
      chk("full_w1_en", 32'(regWrite), 1);
      cyc();
      chk("full_w2", {writeIndex, writeData[26:0]}, {5'd5, 27'h55});
      chk("full_w2_en", 32'(regWrite), 1);
      cyc();
      chk("full_w3", {writeIndex, writeData[26:0]}, {5'd6, 27'h66});
      chk("full_w3_en", 32'(regWrite), 1);
      cyc();
      chk("full_w4", {writeIndex, writeData[26:0]}, {5'd7, 27'h77});
      chk("full_w4_en", 32'(regWrite), 1);
      chk("full_empty", 32'(pending), 0);
      cyc();
      chk("full_done", 32'(regWrite), 0);

      // index 0 is accepted but dropped
      alu_valid = 1; alu_index = 0; alu_data = 32'hFFFFFFFF; indexA = 0; #1;
      chk("idx0_ready", 32'(alu_ready), 1);
      cyc(); idle(); #1;
      chk("idx0_pending", 32'(pending), 0);
      chk("idx0_fwd_valid", 32'(fwdA_valid), 0);
      chk("idx0_fwd_data", fwdA_data, 0);
      cyc();
      chk("idx0_no_write", 32'(regWrite), 0);

      // wrap-around stream r1..r10
      exp_next = 1;
      for (int i = 1; i <= 14; i++) begin
         if (i <= 10) begin
            alu_valid = 1; alu_index = 5'(i); alu_data = 32'h100 + 32'(i);
         end else idle();
         cyc();
         if (regWrite) begin
            chk("wrap_index", 32'(writeIndex), 32'(exp_next));
            chk("wrap_data", writeData, 32'h100 + 32'(exp_next));
            exp_next++;
         end
         chk("wrap_pending_le4", 32'(pending <= 5'd4), 1);
      end
      chk("wrap_write_count", 32'(exp_next), 11);

      // reset mid-queue with a write in flight
      wb_stall = 1;
      alu_valid = 1; alu_index = 9;  alu_data = 32'h99;
      mem_valid = 1; mem_index = 10; mem_data = 32'hAA;
      cyc();
      wb_stall = 0;
      alu_index = 11; alu_data = 32'hBB;
      mem_index = 12; mem_data = 32'hCC;
      cyc(); idle(); wb_stall = 1; #1;
      chk("mid_pending3", 32'(pending), 3);
      chk("mid_inflight", 32'(regWrite), 1);
      chk("mid_inflight_idx", 32'(writeIndex), 9);
      RST = 1; #1;
      chk("mid_rst_regWrite", 32'(regWrite), 0);
      chk("mid_rst_pending", 32'(pending), 0);
      chk("mid_rst_writeIndex", 32'(writeIndex), 0);
      chk("mid_rst_writeData", writeData, 0);
      cyc();
      RST = 0; wb_stall = 0; indexA = 11; #1;
      chk("mid_alu_ready", 32'(alu_ready), 1);
      chk("mid_mem_ready", 32'(mem_ready), 1);
      chk("mid_fwd_cleared", 32'(fwdA_valid), 0);
      cyc();
      chk("mid_no_write", 32'(regWrite), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
